// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and dmem.
// One outstanding transaction at a time. Dmem has priority. A control-hazard
// flush cancels delivery of an in-flight fetch response.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// dmem wins with fetch waiting, fetch is granted once. Without it, dmem
// priority is strict.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [3:0]        dm_be,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state;
    logic   owner_if;   // 1: current transaction belongs to fetch
    logic   drop;       // fetch response must be swallowed
    logic   idle;
    logic   force_if;
    logic   dm_win;
    logic   if_win;
    logic   resp;

    // The legal limit range only matters when the guard is built in.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_unused
    end

    assign idle   = (state == IDLE) & ~RST;
    assign dm_win = idle & dm_req & ~(if_req & force_if);
    assign if_win = idle & if_req & ~dm_win;
    assign dm_gnt = dm_win;
    assign if_gnt = if_win;

    // Responses are only honoured while a command is in flight.
    assign resp      = (state == WAIT) & mem_rvalid;
    assign dm_rvalid = resp & ~owner_if;
    assign if_rvalid = resp & owner_if & ~drop;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;

    assign stall_if = ~RST & ((if_req & ~if_gnt) |
                              (owner_if & (state != IDLE) & ~drop & ~if_rvalid));

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    assign force_if = (starve_cnt == 4'(STARVE_LIMIT));

    // Count dmem wins that left a fetch waiting; any fetch win resets it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         starve_cnt <= '0;
        else if (if_win) starve_cnt <= '0;
        else if (dm_win) starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
    end
`else
    assign force_if = 1'b0;
`endif

    // Transaction FSM: capture command on grant, wait for accept, then response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            owner_if  <= 1'b0;
            drop      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_win) begin
                        state     <= REQ;
                        owner_if  <= 1'b0;
                        drop      <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_be;
                    end else if (if_win) begin
                        state     <= REQ;
                        owner_if  <= 1'b1;
                        drop      <= flush;   // flush in the grant cycle kills it
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= 4'hF;
                    end
                end
                REQ: begin
                    if (owner_if && flush) drop <= 1'b1;
                    if (mem_ready) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (owner_if && flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          flush = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_be = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall_if(stall_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the one outstanding transaction as a record.
    bit            m_busy, m_issued, m_own_if, m_drop;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_be;
    int            m_cnt;

    // Protocol observations feeding the stimulus generators.
    bit seen_if_gnt, seen_dm_gnt, seen_accept;
    bit gnt_log[$];   // 1 = fetch won, 0 = dmem won

    always @(negedge CLK) begin
        logic e_ifg, e_dmg, frc, rv, e_ifv, e_dmv, e_stall, e_mreq;
        if (RST) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_gnt", {if_gnt, dm_gnt}, 0);
            chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
            chk("rst_stall", stall_if, 0);
            m_busy = 0; m_issued = 0; m_own_if = 0; m_drop = 0; m_cnt = 0;
            seen_if_gnt = 0; seen_dm_gnt = 0; seen_accept = 0;
        end else begin
            frc    = GUARD && (m_cnt == LIM);
            e_dmg  = !m_busy && dm_req && !(if_req && frc);
            e_ifg  = !m_busy && if_req && !e_dmg;
            e_mreq = m_busy && !m_issued;
            rv     = m_busy && m_issued && mem_rvalid;
            e_dmv  = rv && !m_own_if;
            e_ifv  = rv && m_own_if && !m_drop;
            e_stall = (if_req && !e_ifg) || (m_busy && m_own_if && !m_drop && !e_ifv);

            chk("if_gnt", if_gnt, e_ifg);
            chk("dm_gnt", dm_gnt, e_dmg);
            chk("mem_req", mem_req, e_mreq);
            if (e_mreq) begin
                chk("mem_we", mem_we, m_we);
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("mem_be", mem_be, m_be);
            end
            chk("if_rvalid", if_rvalid, e_ifv);
            chk("if_rdata", if_rdata, e_ifv ? mem_rdata : '0);
            chk("dm_rvalid", dm_rvalid, e_dmv);
            chk("dm_rdata", dm_rdata, e_dmv ? mem_rdata : '0);
            chk("stall_if", stall_if, e_stall);

            if (if_gnt || dm_gnt) gnt_log.push_back(if_gnt);
            seen_if_gnt = if_gnt;
            seen_dm_gnt = dm_gnt;
            seen_accept = mem_req && mem_ready;

            // advance the model to the next cycle
            if (!m_busy) begin
                if (e_dmg) begin
                    m_busy = 1; m_issued = 0; m_own_if = 0; m_drop = 0;
                    m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
                    m_cnt = if_req ? m_cnt + 1 : 0;
                end else if (e_ifg) begin
                    m_busy = 1; m_issued = 0; m_own_if = 1; m_drop = flush;
                    m_we = 0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
                    m_cnt = 0;
                end
            end else begin
                if (m_own_if && flush) m_drop = 1;
                if (!m_issued) begin
                    if (mem_ready) m_issued = 1;
                end else if (mem_rvalid) begin
                    m_busy = 0; m_drop = 0;
                end
            end
        end
    end

    // Random stimulus knobs (percent) and memory responder state.
    int if_pct, dm_pct, rdy_pct, fl_pct;
    bit pend;
    int lat;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        if (mem_rvalid) begin
            mem_rvalid = 0; mem_rdata = '0;
        end else begin
            if (seen_accept) begin pend = 1; lat = $urandom_range(0, 2); end
            else if (pend && lat > 0) lat--;
            if (pend && lat == 0) begin
                mem_rvalid = 1; mem_rdata = $urandom; pend = 0;
            end
        end
        mem_ready = ($urandom_range(0, 99) < rdy_pct);
        flush     = ($urandom_range(0, 99) < fl_pct);
        if (if_req && seen_if_gnt) if_req = 0;
        if (!if_req && $urandom_range(0, 99) < if_pct) begin
            if_req = 1; if_addr = AW'($urandom_range(0, 1023)) << 2;
        end
        if (dm_req && seen_dm_gnt) dm_req = 0;
        if (!dm_req && $urandom_range(0, 99) < dm_pct) begin
            dm_req = 1; dm_we = $urandom_range(0, 1);
            dm_addr = AW'($urandom_range(0, 4095)) << 2;
            dm_wdata = $urandom; dm_be = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic do_reset();
        RST = 1; if_req = 0; dm_req = 0; flush = 0;
        mem_rvalid = 0; mem_ready = 0; mem_rdata = '0; pend = 0;
        repeat (2) step();
        RST = 0;
    endtask

    initial begin
        do_reset();

        // lone fetch, minimum latency
        step(); if_req = 1; if_addr = 32'h100; mem_ready = 1;
        @(negedge CLK); chk("lone_gnt", if_gnt, 1);
        step(); if_req = 0;
        @(negedge CLK); chk("lone_mem_req", mem_req, 1); chk("lone_mem_addr", mem_addr, 32'h100);
        step(); mem_rvalid = 1; mem_rdata = 32'h13;
        @(negedge CLK); chk("lone_rvalid", if_rvalid, 1); chk("lone_rdata", if_rdata, 32'h13);
        step(); mem_rvalid = 0; mem_rdata = '0;
        @(negedge CLK); chk("lone_stall_low", stall_if, 0);

        // contention: store wins, fetch granted after its response
        step(); if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF;
        @(negedge CLK); chk("cont_dm_gnt", dm_gnt, 1); chk("cont_if_gnt0", if_gnt, 0);
        step(); dm_req = 0; dm_we = 0;
        @(negedge CLK); chk("cont_mem_we", mem_we, 1); chk("cont_wdata", mem_wdata, 32'hDEADBEEF);
        step(); mem_rvalid = 1;
        @(negedge CLK); chk("cont_dm_rvalid", dm_rvalid, 1); chk("cont_if_gnt1", if_gnt, 0);
        step(); mem_rvalid = 0;
        @(negedge CLK); chk("cont_if_gnt2", if_gnt, 1);
        step(); if_req = 0;
        step(); mem_rvalid = 1; mem_rdata = 32'h17;
        @(negedge CLK); chk("cont_if_rvalid", if_rvalid, 1);
        step(); mem_rvalid = 0; mem_rdata = '0;

        // backpressure: fields stable while a new dmem request waits
        step(); dm_req = 1; dm_we = 0; dm_addr = 32'h40; dm_be = 4'h3; mem_ready = 0;
        @(negedge CLK); chk("bp_gnt", dm_gnt, 1);
        step(); dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h1234; dm_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            mem_ready = (i == 3);
            @(negedge CLK);
            chk("bp_mem_req", mem_req, 1); chk("bp_mem_addr", mem_addr, 32'h40);
            chk("bp_mem_be", mem_be, 4'h3); chk("bp_no_gnt", dm_gnt, 0);
        end
        step(); mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
        @(negedge CLK); chk("bp_rvalid", dm_rvalid, 1); chk("bp_rdata", dm_rdata, 32'hCAFE0001);
        step(); mem_rvalid = 0; mem_rdata = '0;
        @(negedge CLK); chk("bp_gnt2", dm_gnt, 1);
        step(); dm_req = 0;
        step(); mem_rvalid = 1;
        @(negedge CLK); chk("bp_rvalid2", dm_rvalid, 1);
        step(); mem_rvalid = 0;

        // flush while fetch waits for its response
        step(); if_req = 1; if_addr = 32'h200; mem_ready = 1;
        @(negedge CLK); chk("fl_gnt", if_gnt, 1);
        step(); if_req = 0;
        step(); flush = 1;
        @(negedge CLK); chk("fl_stall_hi", stall_if, 1);
        step(); flush = 0;
        @(negedge CLK); chk("fl_stall_lo", stall_if, 0);
        step(); mem_rvalid = 1; mem_rdata = 32'hABCD; if_req = 1; if_addr = 32'h300;
        @(negedge CLK); chk("fl_no_rvalid", if_rvalid, 0); chk("fl_rdata0", if_rdata, 0);
        step(); mem_rvalid = 0; mem_rdata = '0;
        @(negedge CLK); chk("fl_next_gnt", if_gnt, 1);
        step(); if_req = 0;
        step(); mem_rvalid = 1; mem_rdata = 32'h99;
        @(negedge CLK); chk("fl_next_rvalid", if_rvalid, 1);
        step(); mem_rvalid = 0; mem_rdata = '0;

        // asynchronous reset while a command is pending
        step(); dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h77; dm_be = 4'hF;
        mem_ready = 0;
        @(negedge CLK); chk("ar_gnt", dm_gnt, 1);
        step(); dm_req = 0;
        @(negedge CLK); chk("ar_mem_req", mem_req, 1);
        #2 RST = 1;
        #1 chk("ar_async_drop", mem_req, 0); chk("ar_mem_we", mem_we, 0);
        step(); step(); RST = 0;
        step(); mem_rvalid = 1; mem_rdata = 32'h55;
        @(negedge CLK); chk("ar_late_rvalid", {dm_rvalid, if_rvalid}, 0); chk("ar_rdata", dm_rdata, 0);
        step(); mem_rvalid = 0; mem_rdata = '0;

        // randomized traffic
        pend = 0; if_pct = 40; dm_pct = 40; rdy_pct = 70; fl_pct = 10;
        repeat (3000) begin step(); drive(); end

        // starvation: both requesters held from reset
        do_reset();
        gnt_log.delete();
        if_pct = 100; dm_pct = 100; rdy_pct = 100; fl_pct = 0;
        repeat (40) begin step(); drive(); end
        chk("starve_log_len", gnt_log.size() >= 6, 1);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk($sformatf("starve_seq%0d", i), gnt_log[i], GUARD && (i == 4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
